hazard_ctrl: RTL and testbench
==============================

// Module: hazard_ctrl
// PURPOSE
//   Pipeline sequencer for the 5-stage CPU. Drives the write/flush/hold controls of PC, IF/ID, ID/EX and EX/MEM.
//   Resolves load-use hazards, taken branches (resolved in EX), jumps (resolved in ID) and multi-cycle memory waits.
//   Keeps saturating stall/flush performance counters and a sticky memory-timeout flag.
// PARAMETERS
//   MEM_TIMEOUT  256  max consecutive MEM_Busy cycles tolerated before timeout (>=2)
//   CNT_W        16   width of performance counters (saturating)
// PORTS
//   clk            in   1      system clock, rising edge
//   reset          in   1      synchronous, active-high
//   ID_rs          in   5      rs field of instruction in ID
//   ID_rt          in   5      rt field of instruction in ID
//   ID_UsesRs      in   1      ID instruction reads rs
//   ID_UsesRt      in   1      ID instruction reads rt
//   ID_Jump        in   1      ID instruction is j/jal/jr/jalr
//   EX_MemRead     in   1      instruction in EX is a load
//   EX_WrReg       in   5      destination register of instruction in EX
//   EX_BranchTaken in   1      branch in EX resolved taken
//   MEM_Busy       in   1      data memory/peripheral not ready this cycle
//   PC_Write       out  1      PC may update
//   IF_ID_Write    out  1      IF/ID may load
//   IF_ID_Flush    out  1      IF/ID loads bubble
//   ID_EX_Flush    out  1      ID/EX loads bubble (drives its flush input)
//   ID_EX_Hold     out  1      ID/EX keeps contents
//   EX_MEM_Hold    out  1      EX/MEM keeps contents
//   MemTimeout     out  1      sticky: a memory wait exceeded MEM_TIMEOUT
//   StallCycles    out  CNT_W  cycles with PC_Write=0 since reset
//   FlushCount     out  CNT_W  cycles with IF_ID_Flush=1 since reset
// BEHAVIOUR
//   Control outputs combinational from registered state + inputs; counters/flag registered.
//   Reset (reset=1 at edge): state<=RUN, counters<=0, MemTimeout<=0, wait counter<=0.
//     While reset=1: PC_Write=0, IF_ID_Write=0, IF_ID_Flush=1, ID_EX_Flush=1, holds=0.
//   Default (RUN, no event): PC_Write=1, IF_ID_Write=1, flushes=0, holds=0.
//   FSM states: RUN, WAIT_MEM, DRAIN.
//     RUN + MEM_Busy      -> freeze this cycle; next WAIT_MEM, wait counter<=1.
//     WAIT_MEM + MEM_Busy -> freeze; wait counter+1.
//       At MEM_TIMEOUT-1 -> MemTimeout<=1, next DRAIN.
//     WAIT_MEM + !MEM_Busy -> no freeze this cycle (normal priority rules), next RUN.
//     DRAIN -> MEM_Busy ignored (no freeze); next RUN on first cycle with MEM_Busy=0.
//   Freeze: PC_Write=0, IF_ID_Write=0, ID_EX_Hold=1, EX_MEM_Hold=1, flushes=0.
//   Priority per cycle (highest first): reset > freeze > EX_BranchTaken > load-use > ID_Jump.
//     EX_BranchTaken: PC_Write=1, IF_ID_Flush=1, ID_EX_Flush=1.
//     Load-use: EX_MemRead && EX_WrReg!=0 && ((ID_UsesRs && ID_rs==EX_WrReg) || (ID_UsesRt && ID_rt==EX_WrReg)).
//       Response: PC_Write=0, IF_ID_Write=0, ID_EX_Flush=1. Exactly one cycle, since the bubble clears EX_MemRead.
//     ID_Jump: IF_ID_Flush=1 only.
//   Branch arriving during freeze is held in EX and acted on the first unfrozen cycle.
//   Counters saturate at all-ones, never wrap. Increment on the edge after the qualifying cycle.
//   MemTimeout clears only on reset. Reset mid-wait returns to RUN immediately.
// STRUCTURE
//   hazard_pkg: state encoding (RUN=2'd0, WAIT_MEM=2'd1, DRAIN=2'd2), REG_ZERO=5'd0.
//   Sub-module sat_counter #(W) (clk, reset, inc, q). Instantiated twice, for StallCycles and FlushCount.
// TESTING
//   Load-use: lw $t0 in EX (EX_WrReg=8), ID_rs=8, ID_UsesRs=1 -> one cycle PC_Write=0, ID_EX_Flush=1; StallCycles=1.
//   EX_WrReg=0 with a matching load -> no stall, all defaults.
//   Branch+load-use same cycle -> PC_Write=1, IF_ID_Flush=1, ID_EX_Flush=1; FlushCount increments, StallCycles does not.
//   MEM_Busy high 3 cycles -> freeze 3 cycles, state WAIT_MEM. 4th cycle released, state RUN; StallCycles=3.
//   MEM_TIMEOUT=4, MEM_Busy stuck high:
//     freeze for 4 cycles; MemTimeout=1; DRAIN with no freeze;
//     RUN after MEM_Busy drops; MemTimeout stays 1 until reset.
//   Reset asserted in WAIT_MEM -> outputs take the reset-asserted values; after release: RUN, counters 0, MemTimeout 0.

Source files
------------

// File: rtl/hazard_pkg.sv
// Shared definitions for the pipeline hazard sequencer.
//   state_t  : sequencer FSM encoding (RUN, WAIT_MEM, DRAIN)
//   REG_ZERO : architectural zero register; a load targeting it never creates a hazard
package hazard_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    WAIT_MEM = 2'd1,
    DRAIN    = 2'd2
  } state_t;

  localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter used for the pipeline performance counters.
//   clk   : clock, rising edge
//   reset : synchronous active-high clear
//   inc   : count this cycle (takes effect on the next edge)
//   q     : current count; sticks at all-ones instead of wrapping
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  output logic [W-1:0] q
);

  logic [W-1:0] q_q;
  logic [W-1:0] q_d;

  always_comb begin
    q_d = q_q;
    if (inc && (q_q != {W{1'b1}})) begin
      q_d = q_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q = q_q;

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline sequencer for the 5-stage CPU. Produces the write/flush/hold
// controls for PC, IF/ID, ID/EX and EX/MEM, resolving load-use hazards,
// taken branches (EX), jumps (ID) and multi-cycle memory waits.
//   clk, reset            : clock and synchronous active-high reset
//   ID_rs/ID_rt/ID_Uses*  : source operands of the instruction in ID
//   ID_Jump               : ID holds j/jal/jr/jalr
//   EX_MemRead/EX_WrReg   : load in EX and its destination
//   EX_BranchTaken        : branch in EX resolved taken
//   MEM_Busy              : memory not ready this cycle
//   PC_Write..EX_MEM_Hold : pipeline register controls (combinational)
//   MemTimeout            : sticky, a memory wait ran too long
//   StallCycles/FlushCount: saturating performance counters
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int MEM_TIMEOUT = 256,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       ID_rs,
  input  logic [4:0]       ID_rt,
  input  logic             ID_UsesRs,
  input  logic             ID_UsesRt,
  input  logic             ID_Jump,
  input  logic             EX_MemRead,
  input  logic [4:0]       EX_WrReg,
  input  logic             EX_BranchTaken,
  input  logic             MEM_Busy,
  output logic             PC_Write,
  output logic             IF_ID_Write,
  output logic             IF_ID_Flush,
  output logic             ID_EX_Flush,
  output logic             ID_EX_Hold,
  output logic             EX_MEM_Hold,
  output logic             MemTimeout,
  output logic [CNT_W-1:0] StallCycles,
  output logic [CNT_W-1:0] FlushCount
);

  localparam int              WC_W      = $clog2(MEM_TIMEOUT) + 1;
  localparam logic [WC_W-1:0] WAIT_LAST = WC_W'(MEM_TIMEOUT - 1);

  state_t          state_q, state_d;
  logic [WC_W-1:0] wait_cnt_q, wait_cnt_d;
  logic            mem_timeout_q, mem_timeout_d;
  logic            freeze;
  logic            load_use;

  // DRAIN deliberately ignores MEM_Busy so a hung peripheral cannot
  // deadlock the pipeline once the timeout has been flagged.
  assign freeze = MEM_Busy && ((state_q == RUN) || (state_q == WAIT_MEM));

  assign load_use = EX_MemRead && (EX_WrReg != REG_ZERO) &&
                    ((ID_UsesRs && (ID_rs == EX_WrReg)) ||
                     (ID_UsesRt && (ID_rt == EX_WrReg)));

  // Pipeline controls, highest priority first.
  always_comb begin
    PC_Write    = 1'b1;
    IF_ID_Write = 1'b1;
    IF_ID_Flush = 1'b0;
    ID_EX_Flush = 1'b0;
    ID_EX_Hold  = 1'b0;
    EX_MEM_Hold = 1'b0;
    if (reset) begin
      PC_Write    = 1'b0;
      IF_ID_Write = 1'b0;
      IF_ID_Flush = 1'b1;
      ID_EX_Flush = 1'b1;
    end else if (freeze) begin
      // A taken branch stays held in EX and is handled once unfrozen.
      PC_Write    = 1'b0;
      IF_ID_Write = 1'b0;
      ID_EX_Hold  = 1'b1;
      EX_MEM_Hold = 1'b1;
    end else if (EX_BranchTaken) begin
      IF_ID_Flush = 1'b1;
      ID_EX_Flush = 1'b1;
    end else if (load_use) begin
      // The injected bubble clears EX_MemRead, so this lasts one cycle.
      PC_Write    = 1'b0;
      IF_ID_Write = 1'b0;
      ID_EX_Flush = 1'b1;
    end else if (ID_Jump) begin
      IF_ID_Flush = 1'b1;
    end
  end

  // Memory-wait sequencing.
  always_comb begin
    state_d       = state_q;
    wait_cnt_d    = wait_cnt_q;
    mem_timeout_d = mem_timeout_q;
    case (state_q)
      RUN: begin
        if (MEM_Busy) begin
          state_d    = WAIT_MEM;
          wait_cnt_d = WC_W'(1);
        end
      end
      WAIT_MEM: begin
        if (!MEM_Busy) begin
          state_d    = RUN;
          wait_cnt_d = '0;
        end else if (wait_cnt_q == WAIT_LAST) begin
          state_d       = DRAIN;
          wait_cnt_d    = '0;
          mem_timeout_d = 1'b1;
        end else begin
          wait_cnt_d = wait_cnt_q + 1'b1;
        end
      end
      DRAIN: begin
        if (!MEM_Busy) begin
          state_d = RUN;
        end
      end
      default: begin
        state_d    = RUN;
        wait_cnt_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= RUN;
      wait_cnt_q    <= '0;
      mem_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      wait_cnt_q    <= wait_cnt_d;
      mem_timeout_q <= mem_timeout_d;
    end
  end

  assign MemTimeout = mem_timeout_q;

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (!PC_Write),
    .q     (StallCycles)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (IF_ID_Flush),
    .q     (FlushCount)
  );

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl (MEM_TIMEOUT=4, 4-bit counters so that
// saturation is reachable in a few cycles).
module tb_hazard_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] ID_rs, ID_rt, EX_WrReg;
  logic       ID_UsesRs, ID_UsesRt, ID_Jump, EX_MemRead, EX_BranchTaken, MEM_Busy;
  logic       PC_Write, IF_ID_Write, IF_ID_Flush, ID_EX_Flush, ID_EX_Hold, EX_MEM_Hold;
  logic       MemTimeout;
  logic [3:0] StallCycles, FlushCount;
  logic [5:0] ctl;

  int total = 0;
  int bad   = 0;

  // {PC_Write, IF_ID_Write, IF_ID_Flush, ID_EX_Flush, ID_EX_Hold, EX_MEM_Hold}
  localparam logic [5:0] C_DEF = 6'b110000;
  localparam logic [5:0] C_RST = 6'b001100;
  localparam logic [5:0] C_FRZ = 6'b000011;
  localparam logic [5:0] C_LU  = 6'b000100;
  localparam logic [5:0] C_BR  = 6'b111100;
  localparam logic [5:0] C_JMP = 6'b111000;

  hazard_ctrl #(.MEM_TIMEOUT(4), .CNT_W(4)) dut (
    .clk(clk), .reset(reset),
    .ID_rs(ID_rs), .ID_rt(ID_rt), .ID_UsesRs(ID_UsesRs), .ID_UsesRt(ID_UsesRt),
    .ID_Jump(ID_Jump), .EX_MemRead(EX_MemRead), .EX_WrReg(EX_WrReg),
    .EX_BranchTaken(EX_BranchTaken), .MEM_Busy(MEM_Busy),
    .PC_Write(PC_Write), .IF_ID_Write(IF_ID_Write), .IF_ID_Flush(IF_ID_Flush),
    .ID_EX_Flush(ID_EX_Flush), .ID_EX_Hold(ID_EX_Hold), .EX_MEM_Hold(EX_MEM_Hold),
    .MemTimeout(MemTimeout), .StallCycles(StallCycles), .FlushCount(FlushCount)
  );

  assign ctl = {PC_Write, IF_ID_Write, IF_ID_Flush, ID_EX_Flush, ID_EX_Hold, EX_MEM_Hold};

  always #5 clk = ~clk;

  // Advance one clock; returns 1 time unit after the rising edge, then
  // another unit for combinational settling before any check.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    ID_rs = 5'd0; ID_rt = 5'd0; ID_UsesRs = 1'b0; ID_UsesRt = 1'b0;
    ID_Jump = 1'b0; EX_MemRead = 1'b0; EX_WrReg = 5'd0;
    EX_BranchTaken = 1'b0; MEM_Busy = 1'b0;
  endtask

  task automatic set_lu(input logic [4:0] wr, input logic [4:0] rs, input logic [4:0] rt,
                        input logic urs, input logic urt);
    EX_MemRead = 1'b1; EX_WrReg = wr; ID_rs = rs; ID_rt = rt;
    ID_UsesRs = urs; ID_UsesRt = urt;
  endtask

  task automatic chk_ctl(input string name, input logic [5:0] exp);
    #1;
    total++;
    $display("%s ctl=%b exp=%b", name, ctl, exp);
    if (ctl !== exp) begin
      bad++;
      $display("FAIL %s ctl got=%b want=%b", name, ctl, exp);
    end
  endtask

  task automatic chk_cnt(input string name, input logic [3:0] es, input logic [3:0] ef,
                         input logic et);
    total++;
    $display("%s stall=%0d flush=%0d tmo=%b", name, StallCycles, FlushCount, MemTimeout);
    if ({StallCycles, FlushCount, MemTimeout} !== {es, ef, et}) begin
      bad++;
      $display("FAIL %s stall/flush/tmo got=%0d/%0d/%b want=%0d/%0d/%b",
               name, StallCycles, FlushCount, MemTimeout, es, ef, et);
    end
  endtask

  task automatic test_reset();
    chk_ctl("reset_held", C_RST);
    cyc();
    reset = 1'b0; idle();
    chk_ctl("reset_release", C_DEF);
    chk_cnt("reset_counters", 4'd0, 4'd0, 1'b0);
  endtask

  task automatic test_load_use();
    set_lu(5'd8, 5'd8, 5'd3, 1'b1, 1'b0);
    chk_ctl("lu_rs", C_LU);
    cyc(); idle();
    chk_ctl("lu_rs_after", C_DEF);
    chk_cnt("lu_rs_cnt", 4'd1, 4'd0, 1'b0);
    set_lu(5'd9, 5'd2, 5'd9, 1'b0, 1'b1);
    chk_ctl("lu_rt", C_LU);
    cyc();
    set_lu(5'd9, 5'd9, 5'd4, 1'b0, 1'b1);
    chk_ctl("lu_rs_unused", C_DEF);
    cyc(); idle();
    chk_cnt("lu_rt_cnt", 4'd2, 4'd0, 1'b0);
  endtask

  task automatic test_zero_reg();
    set_lu(5'd0, 5'd0, 5'd0, 1'b1, 1'b1);
    chk_ctl("zero_reg", C_DEF);
    cyc(); idle();
    chk_cnt("zero_reg_cnt", 4'd2, 4'd0, 1'b0);
  endtask

  task automatic test_branch_jump();
    set_lu(5'd8, 5'd8, 5'd0, 1'b1, 1'b0);
    EX_BranchTaken = 1'b1;
    chk_ctl("branch_over_lu", C_BR);
    cyc(); idle();
    chk_cnt("branch_cnt", 4'd2, 4'd1, 1'b0);
    ID_Jump = 1'b1;
    chk_ctl("jump", C_JMP);
    cyc();
    set_lu(5'd5, 5'd5, 5'd0, 1'b1, 1'b0);
    chk_ctl("lu_over_jump", C_LU);
    cyc(); idle();
    chk_cnt("jump_cnt", 4'd3, 4'd2, 1'b0);
  endtask

  task automatic test_mem_wait();
    MEM_Busy = 1'b1;
    chk_ctl("wait_c1", C_FRZ);
    cyc();
    EX_BranchTaken = 1'b1;
    chk_ctl("wait_c2_branch", C_FRZ);
    cyc();
    chk_ctl("wait_c3_branch", C_FRZ);
    cyc();
    MEM_Busy = 1'b0;
    chk_ctl("wait_release_branch", C_BR);
    cyc(); idle();
    chk_ctl("wait_run", C_DEF);
    chk_cnt("wait_cnt", 4'd6, 4'd3, 1'b0);
  endtask

  task automatic test_timeout();
    MEM_Busy = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk_ctl($sformatf("tmo_freeze%0d", i), C_FRZ);
      cyc();
    end
    chk_ctl("tmo_drain1", C_DEF);
    chk_cnt("tmo_flag", 4'd10, 4'd3, 1'b1);
    cyc();
    chk_ctl("tmo_drain2", C_DEF);
    cyc();
    MEM_Busy = 1'b0;
    cyc();
    MEM_Busy = 1'b1;
    chk_ctl("tmo_back_to_run", C_FRZ);
    cyc();
    MEM_Busy = 1'b0;
    chk_ctl("tmo_release", C_DEF);
    cyc();
    chk_cnt("tmo_sticky", 4'd11, 4'd3, 1'b1);
  endtask

  task automatic test_reset_mid_wait();
    MEM_Busy = 1'b1;
    cyc();
    reset = 1'b1;
    chk_ctl("rst_in_wait", C_RST);
    cyc();
    reset = 1'b0; MEM_Busy = 1'b0;
    chk_ctl("rst_wait_release", C_DEF);
    chk_cnt("rst_wait_cnt", 4'd0, 4'd0, 1'b0);
    MEM_Busy = 1'b1;
    chk_ctl("rst_wait_refreeze", C_FRZ);
    cyc();
    MEM_Busy = 1'b0;
    cyc();
  endtask

  task automatic test_saturation();
    set_lu(5'd7, 5'd7, 5'd0, 1'b1, 1'b0);
    repeat (20) cyc();
    idle();
    chk_cnt("stall_saturate", 4'd15, 4'd0, 1'b0);
  endtask

  initial begin
    reset = 1'b1;
    idle();
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    test_load_use();
    test_zero_reg();
    test_branch_jump();
    test_mem_wait();
    test_timeout();
    test_reset_mid_wait();
    test_saturation();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
